cpu_state_dumper: RTL
=====================

// Module: cpu_state_dumper
// PURPOSE
//  Streams the architectural state of the pipelined CPU (PC, then R0..R31) out as 33 words over a valid/ready interface.
//  A dump is started by request; the unit reads registers through the register file's debug read port.
//  Hardware source for the same PC/register trace the simulation monitor prints each cycle; usable on FPGA/post-synthesis.
//  Sits beside CPU: taps PC.pc_o and a Registers debug port; asserts freeze_o so the CPU can hold state during a frame.
// PARAMETERS
//  DATA_W    32  width of PC, registers and stream words
//  NUM_REGS  32  registers per frame (R0..NUM_REGS-1)
//  IDX_W     6   width of word index; must satisfy 2**IDX_W >= NUM_REGS+1
//  DROP_W    8   width of saturating dropped-request counter
// PORTS
//  clk_i         in   1               clock; all state updates on rising edge
//  rst_i         in   1               synchronous, active-high reset
//  req_i         in   1               dump request, sampled each edge
//  pc_i          in   DATA_W          current PC (PC.pc_o)
//  dbg_addr_o    out  $clog2(NUM_REGS) register-file debug read address
//  dbg_data_i    in   DATA_W          register-file debug read data, combinational from dbg_addr_o
//  dout_o        out  DATA_W          stream word
//  dout_idx_o    out  IDX_W           word index: 0 = PC, k = R(k-1)
//  dout_valid_o  out  1               stream word valid
//  dout_last_o   out  1               high with final word (R[NUM_REGS-1])
//  dout_ready_i  in   1               sink ready; transfer = valid & ready at rising edge
//  busy_o        out  1               frame in progress
//  freeze_o      out  1               request CPU stall; equals busy_o
//  drop_cnt_o    out  DROP_W          requests ignored while busy (saturating)
// BEHAVIOUR
//  Reset: state IDLE; dout_o=0, dout_idx_o=0, valid/last/busy/freeze=0, drop_cnt_o=0, dbg_addr_o=0.
//  FSM: IDLE -> SEND on req_i; SEND -> IDLE on transfer of the last word; no other states.
//  IDLE & req_i at edge E0: latch dout_o<=pc_i, idx<=0, valid<=1, busy<=1; rd_ptr<=0.
//    PC is snapshotted at E0; register words are read live, one per transfer (freeze_o keeps them stable).
//  SEND: dbg_addr_o = rd_ptr. On a transfer: dout_o<=dbg_data_i, idx<=idx+1, rd_ptr<=rd_ptr+1, valid stays 1.
//  No bubbles: with ready held high, one word per cycle; words transfer at E1..E33; busy_o=0 from E33.
//  Valid-hold: while valid & !ready, dout_o, dout_idx_o and dout_last_o are held unchanged; valid is never withdrawn.
//  dout_last_o = valid & (idx == NUM_REGS). On its transfer: valid<=0, busy<=0, state IDLE.
//  req_i while busy (including the final-transfer edge): ignored; drop_cnt_o += 1, saturates at 2**DROP_W-1.
//  req_i in the cycle after return to IDLE starts a new frame normally (back-to-back frames, 1 idle cycle).
//  rd_ptr is $clog2(NUM_REGS) wide; it is never incremented beyond NUM_REGS-1 (the last read is not followed by one).
//  R0 is emitted as returned by dbg_data_i; no forcing to zero in this block.
//  rst_i mid-frame: frame aborted at that edge, all outputs return to reset values, no last word emitted.
//    rst_i dominates req_i.
//  drop_cnt_o is cleared only by rst_i.
// STRUCTURE
//  Shared package cpu_dbg_defs.vh: state encodings (ST_IDLE, ST_SEND);
//    FRAME_LEN = NUM_REGS+1; IDX_PC = 0; IDX_R0 = 1.
//    Shared with the debug port in Registers.
//  Single module: 1-bit FSM, rd_ptr counter, output holding register, saturating drop counter.
//    No sub-module warranted.
//  Registers needs one extra combinational read port (dbg_addr/dbg_data); that change is outside this block.
// TESTING
//  1. rst_i 2 cycles, then idle 5 cycles
//     -> all outputs 0, busy_o=0, drop_cnt_o=0.
//  2. Preload R[k]=k*3, pc_i=0x40, ready=1, pulse req_i
//     -> 33 transfers on consecutive edges: idx 0 data 0x40, idx k+1 data 3k, last only at idx 32, then busy_o=0.
//  3. As 2 but ready toggles 1,0,0,1,...
//     -> data/idx/last stable while stalled, sequence identical to 2, valid never drops mid-frame.
//  4. req_i held high for 40 cycles, ready=1
//     -> first frame completes, drop_cnt_o counts ignored edges, second frame starts on first idle-cycle req.
//     Also: 300 ignored requests -> drop_cnt_o = 255.
//  5. rst_i asserted while idx=10 is pending
//     -> next cycle valid=0, busy=0, dbg_addr_o=0; new req produces a full fresh frame starting at idx 0.
//  6. pc_i changes each cycle during a frame
//     -> word 0 equals pc_i at the request edge; freeze_o high for exactly the frame duration.

Source files
------------

// File: rtl/cpu_state_dumper_pkg.sv
// Shared definitions for the CPU state dump stream and the register-file debug port.
package cpu_state_dumper_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } dump_state_t;

    localparam int IDX_PC = 0;
    localparam int IDX_R0 = 1;

    // One PC word followed by every architectural register.
    function automatic int frame_len(input int num_regs);
        return num_regs + 1;
    endfunction

endpackage

// File: rtl/cpu_state_dumper.sv
// Streams PC then R0..R(NUM_REGS-1) over valid/ready, reading registers through
// the register-file debug port while holding the CPU frozen for the whole frame.
module cpu_state_dumper
    import cpu_state_dumper_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    parameter  int IDX_W    = 6,
    parameter  int DROP_W   = 8,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic [RA_W-1:0]   dbg_addr_o,
    input  logic [DATA_W-1:0] dbg_data_i,
    output logic [DATA_W-1:0] dout_o,
    output logic [IDX_W-1:0]  dout_idx_o,
    output logic              dout_valid_o,
    output logic              dout_last_o,
    input  logic              dout_ready_i,
    output logic              busy_o,
    output logic              freeze_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(frame_len(NUM_REGS) - 1);
    localparam logic [RA_W-1:0]  LAST_RA  = RA_W'(NUM_REGS - 1);

    dump_state_t       state_q, state_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [RA_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              xfer;
    logic              is_last;

    assign is_last = valid_q && (idx_q == LAST_IDX);
    assign xfer    = valid_q && dout_ready_i;

    // Next-state logic: the held word only moves on an accepted transfer,
    // and requests arriving mid-frame are counted rather than queued.
    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        drop_d   = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d  = ST_SEND;
                    dout_d   = pc_i;
                    idx_d    = IDX_W'(IDX_PC);
                    valid_d  = 1'b1;
                    rd_ptr_d = '0;
                end
            end
            ST_SEND: begin
                if (req_i && (drop_q != '1)) begin
                    drop_d = drop_q + 1'b1;
                end
                if (xfer) begin
                    if (is_last) begin
                        state_d  = ST_IDLE;
                        valid_d  = 1'b0;
                        rd_ptr_d = '0;
                    end else begin
                        dout_d = dbg_data_i;
                        idx_d  = idx_q + 1'b1;
                        // The final register read is not followed by another one.
                        if (rd_ptr_q != LAST_RA) begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            dout_q   <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
        end
    end

    assign dbg_addr_o   = rd_ptr_q;
    assign dout_o       = dout_q;
    assign dout_idx_o   = idx_q;
    assign dout_valid_o = valid_q;
    assign dout_last_o  = is_last;
    assign busy_o       = (state_q == ST_SEND);
    assign freeze_o     = busy_o;
    assign drop_cnt_o   = drop_q;

endmodule
